// File: rtl/wts_timer_pkg.sv
// Shared constants for the wave-table sound cartridge dual interval timer:
// register offsets, control bit positions and the status encoding.
package wts_timer_pkg;

  localparam logic [1:0] REG_T1_CTRL = 2'd0;
  localparam logic [1:0] REG_T1_STAT = 2'd1;
  localparam logic [1:0] REG_T2_CTRL = 2'd2;
  localparam logic [1:0] REG_T2_STAT = 2'd3;

  localparam int CTRL_EN = 7;
  localparam int CTRL_OS = 6;

  localparam logic [7:0] STATUS_IDLE = 8'h80;

  // Status byte reads 0x80 when idle and 0x00 while a flag is pending.
  function automatic logic [7:0] status_byte(input logic pending);
    return pending ? 8'h00 : STATUS_IDLE;
  endfunction

endpackage

// File: rtl/wts_timer_channel.sv
// One interval timer: control register, prescaler, period counter and pending flag.
// pending_next_o exposes the next-state flag so the top can register nint on the same edge.
module wts_timer_channel
  import wts_timer_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int PW       = 6
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       ctrl_wr_i,
  input  logic       stat_clr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] ctrl_o,
  output logic       pending_o,
  output logic       pending_next_o
);

  localparam int PSW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_RELOAD = PSW'(PRESCALE - 1);

  logic [7:0]     ctrl_q, ctrl_d;
  logic [PSW-1:0] pre_q, pre_d;
  logic [PW-1:0]  per_q, per_d;
  logic           pend_q, pend_d;
  logic           expire;

  // A control write outranks expiry, and expiry outranks a status-read clear.
  always_comb begin
    ctrl_d = ctrl_q;
    pre_d  = pre_q;
    per_d  = per_q;
    pend_d = pend_q;
    expire = ctrl_q[CTRL_EN] && (pre_q == '0) && (per_q == '0);
    if (ctrl_wr_i) begin
      ctrl_d = wdata_i;
      pend_d = 1'b0;
      pre_d  = PS_RELOAD;
      per_d  = wdata_i[PW-1:0];
    end else if (expire) begin
      pend_d = 1'b1;
      if (ctrl_q[CTRL_OS]) begin
        ctrl_d[CTRL_EN] = 1'b0;
      end else begin
        pre_d = PS_RELOAD;
        per_d = ctrl_q[PW-1:0];
      end
    end else begin
      if (ctrl_q[CTRL_EN]) begin
        if (pre_q == '0) begin
          pre_d = PS_RELOAD;
          per_d = per_q - PW'(1);
        end else begin
          pre_d = pre_q - PSW'(1);
        end
      end else begin
        pre_d = pre_q;
      end
      if (stat_clr_i) begin
        pend_d = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // Timer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ctrl_q <= 8'h00;
      pre_q  <= '0;
      per_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      pre_q  <= pre_d;
      per_q  <= per_d;
      pend_q <= pend_d;
    end
  end

  assign ctrl_o         = ctrl_q;
  assign pending_o      = pend_q;
  assign pending_next_o = nreset & pend_d;

endmodule

// File: rtl/wts_timer.sv
// Dual interval timer with active-low interrupt request: register decode,
// read mux, registered read data and registered nint.
module wts_timer
  import wts_timer_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int PW       = 6
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [1:0] reg_a,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       nint
);

  logic       rd_eff;
  logic       wr1, wr2, clr1, clr2;
  logic [7:0] ctrl1, ctrl2;
  logic       pend1, pend2, pend1_next, pend2_next;
  logic [7:0] rdata_q, rdata_d;
  logic       nint_q;

  // A read coinciding with a write is dropped.
  assign rd_eff = reg_rd & ~reg_wr;
  assign wr1    = reg_wr && (reg_a == REG_T1_CTRL);
  assign wr2    = reg_wr && (reg_a == REG_T2_CTRL);
  assign clr1   = rd_eff && (reg_a == REG_T1_STAT);
  assign clr2   = rd_eff && (reg_a == REG_T2_STAT);

  wts_timer_channel #(.PRESCALE(PRESCALE), .PW(PW)) u_t1 (
    .clk            (clk),
    .nreset         (nreset),
    .ctrl_wr_i      (wr1),
    .stat_clr_i     (clr1),
    .wdata_i        (reg_wdata),
    .ctrl_o         (ctrl1),
    .pending_o      (pend1),
    .pending_next_o (pend1_next)
  );

  wts_timer_channel #(.PRESCALE(PRESCALE), .PW(PW)) u_t2 (
    .clk            (clk),
    .nreset         (nreset),
    .ctrl_wr_i      (wr2),
    .stat_clr_i     (clr2),
    .wdata_i        (reg_wdata),
    .ctrl_o         (ctrl2),
    .pending_o      (pend2),
    .pending_next_o (pend2_next)
  );

  // Read data returns pre-edge state and holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_eff) begin
      case (reg_a)
        REG_T1_CTRL: rdata_d = ctrl1;
        REG_T1_STAT: rdata_d = status_byte(pend1);
        REG_T2_CTRL: rdata_d = ctrl2;
        REG_T2_STAT: rdata_d = status_byte(pend2);
        default:     rdata_d = 8'h00;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output registers; nint follows the flags' next state.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rdata_q <= 8'h00;
      nint_q  <= 1'b1;
    end else begin
      rdata_q <= rdata_d;
      nint_q  <= ~(pend1_next | pend2_next);
    end
  end

  assign reg_rdata = rdata_q;
  assign nint      = nint_q;

endmodule

// File: doc/wts_timer.md
# wts_timer

Dual interval timer with interrupt request for the wave-table sound cartridge. It sits downstream of the slot bus decoder, which delivers one-cycle register read and write strobes for offsets 0xAEF0–0xAEF3. It produces the active-low interrupt request that the top level drives onto the open-collector slot /INT line. Each timer is independently enabled and runs either one-shot or continuous. A status read returns the pending state and acknowledges it.

## Interface
Parameters:
- PRESCALE, 16, clk cycles per timer tick (≥2); bench uses 16, cartridge build overrides
- PW, 6, period field width

Ports:
- clk  in  1  system clock (21.47727 MHz)
- nreset  in  1  synchronous, active-low reset
- reg_wr  in  1  one-cycle write strobe from bus decoder
- reg_rd  in  1  one-cycle read strobe from bus decoder
- reg_a  in  2  register select: 0 = T1 control, 1 = T1 status, 2 = T2 control, 3 = T2 status
- reg_wdata  in  8  write data
- reg_rdata  out  8  registered read data
- nint  out  1  interrupt request, active-low, registered

## Operation
- Control register, per timer:
  - bit7 = EN
  - bit6 = ONE_SHOT
  - bits[5:0] = N
  - Interval = (N+1)×PRESCALE clk.
- Control write:
  - Loads EN, ONE_SHOT and N.
  - Clears that timer's pending flag.
  - Restarts its prescaler at PRESCALE-1 and its period counter at N.
- EN=1: the prescaler decrements every clk. At prescaler 0 it reloads, and the period counter decrements. Expiry is when both counters are 0.
- On expiry:
  - The pending flag is set.
  - Continuous mode: both counters reload and the timer keeps running.
  - One-shot mode: EN clears and the counters hold.
- EN=0: counters hold. The pending flag is unaffected.
- Status read returns {~pending, 7'b0}: 0x80 when idle, 0x00 when pending. The same edge clears pending.
- Control read returns the current control register, including EN auto-cleared by a one-shot.
- nint = ~(pending1 | pending2). Pending is not masked by EN.
- Writes to status addresses are ignored. reg_wr and reg_rd in the same cycle: the write is performed and the read is ignored.

## Timing
- Reset values:
  - reg_rdata = 0x00
  - nint = 1
  - control = 0x00, both timers
  - pending = 0
  - counters = 0
- A write sampled at edge k gives expiry at edge k + (N+1)×PRESCALE. pending and nint change on that same edge (nint is registered from the next-state).
- A read sampled at edge k updates reg_rdata at edge k, valid from k+1. reg_rdata holds until the next read. The clear takes effect at edge k, and nint deasserts at edge k if no other flag is pending.
- Status read and expiry of the same timer on the same edge: reg_rdata returns the pre-edge value (0x80), and pending ends set, so set wins.
- Control write and expiry on the same edge: the write wins (flag cleared, counters restarted).
- Reset asserted mid-count: all state returns to reset values on the next edge. No expiry is reported.
- N=0 is legal: interval is PRESCALE.
- Counters use unsigned decrement with no wrap past 0. A reload always occurs at 0.

## Structure
- wts_timer_pkg holds:
  - the register offsets
  - control bit positions: EN=7, ONE_SHOT=6
  - STATUS_IDLE=8'h80
- Sub-module wts_timer_channel holds one timer (control reg, prescaler, period counter, pending). It is instantiated twice.
- The top holds the address decode, read mux, reg_rdata register and nint register.
- Expected RTL size is about 180 lines total.

## Test plan
- Reset: nreset low 50 clk, then high → nint=1. Reads of offsets 1 and 3 return 0x80. Reads of 0 and 2 return 0x00.
- One-shot: write 0xC0 to offsets 0 and 2 → nint falls exactly 16 clk after the write edge. Status reads return 0x00 then 0x80. Control read returns 0x40. nint returns to 1 after both status reads.
- Continuous: write 0x82 to offset 0 → pending sets every 48 clk. Reading status between expiries returns 0x00 each time. nint toggles accordingly.
- Simultaneous: place a status read exactly on the expiry edge → read returns 0x80, nint stays 0, and the next read returns 0x00.
- Restart and disable: write 0x85 then rewrite 0x00 at clk 40 → no expiry over 200 clk, nint stays 1. Rewriting 0x85 while pending → pending cleared immediately.
- Reset mid-count: enable 0x8A, pull nreset low at clk 100 → outputs return to reset values. No interrupt occurs after release.
